// File: rtl/sprite_mover_if.sv
// sprite_mover_if
//   Bundles the frame strobe, the four raw direction buttons and the sprite
//   position/status outputs of the sprite motion controller.
//   master : drives frame_tick and buttons, observes position/status
//   slave  : the motion controller itself
//   Signals:
//     frame_tick         one-cycle pulse per frame (start of vblank)
//     btn_up/down/left/right  asynchronous buttons, 1 = pressed
//     centerX, centerY   signed 11-bit sprite centre
//     moving             1 while a direction is being followed
//     hit_wall           one-cycle pulse when the last update was clamped
interface sprite_mover_if;
    logic                     frame_tick;
    logic                     btn_up;
    logic                     btn_down;
    logic                     btn_left;
    logic                     btn_right;
    logic signed [10:0]       centerX;
    logic signed [10:0]       centerY;
    logic                     moving;
    logic                     hit_wall;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right,
        input  centerX, centerY, moving, hit_wall
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right,
        output centerX, centerY, moving, hit_wall
    );
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover
//   Per-frame motion controller for the circle sprite. Buttons are
//   synchronised, then on every frame_tick the centre is moved by the current
//   speed along the held direction(s), speed ramps by one every ACCEL_FRAMES
//   moved frames up to VMAX, and the centre is clamped so the radius-R circle
//   stays inside the HACTIVE x VACTIVE active area.
//   Ports:
//     clk    pixel clock
//     reset  synchronous, active-high
//     bus    sprite_mover_if.slave (frame_tick, buttons in; centre, moving,
//            hit_wall out). All outputs are registered.
module sprite_mover #(
    parameter int HACTIVE      = 800,
    parameter int VACTIVE      = 600,
    parameter int R            = 50,
    parameter int VMAX         = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic           clk,
    input  logic           reset,
    sprite_mover_if.slave  bus
);

    localparam int DATA_W = 11;
    localparam int SUM_W  = 12;
    localparam int SPD_W  = $clog2(VMAX + 1);
    localparam int CNT_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic signed [DATA_W-1:0] X_RST = DATA_W'(HACTIVE / 2);
    localparam logic signed [DATA_W-1:0] Y_RST = DATA_W'(VACTIVE / 2);
    localparam logic signed [SUM_W-1:0]  X_LO  = SUM_W'(R);
    localparam logic signed [SUM_W-1:0]  X_HI  = SUM_W'(HACTIVE - 1 - R);
    localparam logic signed [SUM_W-1:0]  Y_LO  = SUM_W'(R);
    localparam logic signed [SUM_W-1:0]  Y_HI  = SUM_W'(VACTIVE - 1 - R);
    localparam logic [SPD_W-1:0]         SPD_MAX  = SPD_W'(VMAX);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2
    } state_t;

    // Button vectors are ordered {up, down, left, right}.
    logic [3:0]               btn_meta_q, btn_meta_d;
    logic [3:0]               btn_sync_q, btn_sync_d;

    state_t                   state_q, state_d;
    logic [SPD_W-1:0]         speed_q, speed_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] center_x_q, center_x_d;
    logic signed [DATA_W-1:0] center_y_q, center_y_d;
    logic                     moving_q, moving_d;
    logic                     hit_wall_q, hit_wall_d;

    logic [SPD_W-1:0]         spd_cur;
    logic [CNT_W-1:0]         cnt_cur;
    logic signed [SUM_W-1:0]  sum_x;
    logic signed [SUM_W-1:0]  sum_y;
    logic                     hit_x;
    logic                     hit_y;
    logic                     any_dir;

    // Signed step for one axis: +spd, -spd, or 0 when neither or both of the
    // opposing buttons are held.
    function automatic logic signed [SUM_W-1:0] axis_step(
        input logic             pos,
        input logic             neg,
        input logic [SPD_W-1:0] spd
    );
        logic signed [SUM_W-1:0] mag;
        mag = signed'(SUM_W'(spd));
        if (pos && !neg) begin
            axis_step = mag;
        end else if (neg && !pos) begin
            axis_step = -mag;
        end else begin
            axis_step = '0;
        end
    endfunction

    // Saturate a 12-bit candidate into [lo, hi]; flags whether it was clipped.
    function automatic logic signed [DATA_W-1:0] clamp_axis(
        input  logic signed [SUM_W-1:0] v,
        input  logic signed [SUM_W-1:0] lo,
        input  logic signed [SUM_W-1:0] hi,
        output logic                    clipped
    );
        if (v < lo) begin
            clipped    = 1'b1;
            clamp_axis = DATA_W'(lo);
        end else if (v > hi) begin
            clipped    = 1'b1;
            clamp_axis = DATA_W'(hi);
        end else begin
            clipped    = 1'b0;
            clamp_axis = DATA_W'(v);
        end
    endfunction

    function automatic logic [SPD_W-1:0] speed_inc(input logic [SPD_W-1:0] s);
        if (s >= SPD_MAX) begin
            speed_inc = SPD_MAX;
        end else begin
            speed_inc = s + SPD_W'(1);
        end
    endfunction

    always_comb begin
        btn_meta_d = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
        btn_sync_d = btn_meta_q;

        state_d    = state_q;
        speed_d    = speed_q;
        cnt_d      = cnt_q;
        center_x_d = center_x_q;
        center_y_d = center_y_q;
        moving_d   = moving_q;
        hit_wall_d = 1'b0;

        spd_cur    = speed_q;
        cnt_cur    = cnt_q;
        sum_x      = '0;
        sum_y      = '0;
        hit_x      = 1'b0;
        hit_y      = 1'b0;
        any_dir    = ((btn_sync_q[0] ^ btn_sync_q[1]) |
                      (btn_sync_q[2] ^ btn_sync_q[3]));

        if (bus.frame_tick) begin
            if (!any_dir) begin
                state_d = IDLE;
                speed_d = '0;
                cnt_d   = '0;
            end else begin
                // Leaving IDLE starts the ramp at speed 1 before this move.
                if (state_q == IDLE) begin
                    spd_cur = SPD_W'(1);
                    cnt_cur = '0;
                end

                sum_x = $signed({center_x_q[DATA_W-1], center_x_q})
                      + axis_step(btn_sync_q[0], btn_sync_q[1], spd_cur);
                sum_y = $signed({center_y_q[DATA_W-1], center_y_q})
                      + axis_step(btn_sync_q[2], btn_sync_q[3], spd_cur);

                center_x_d = clamp_axis(sum_x, X_LO, X_HI, hit_x);
                center_y_d = clamp_axis(sum_y, Y_LO, Y_HI, hit_y);
                hit_wall_d = hit_x | hit_y;

                if (cnt_cur == CNT_LAST) begin
                    cnt_d   = '0;
                    speed_d = speed_inc(spd_cur);
                end else begin
                    cnt_d   = cnt_cur + CNT_W'(1);
                    speed_d = spd_cur;
                end

                state_d = (speed_d == SPD_MAX) ? CRUISE : RAMP;
            end
            moving_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            state_q    <= IDLE;
            speed_q    <= '0;
            cnt_q      <= '0;
            center_x_q <= X_RST;
            center_y_q <= Y_RST;
            moving_q   <= 1'b0;
            hit_wall_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            state_q    <= state_d;
            speed_q    <= speed_d;
            cnt_q      <= cnt_d;
            center_x_q <= center_x_d;
            center_y_q <= center_y_d;
            moving_q   <= moving_d;
            hit_wall_q <= hit_wall_d;
        end
    end

    assign bus.centerX  = center_x_q;
    assign bus.centerY  = center_y_q;
    assign bus.moving   = moving_q;
    assign bus.hit_wall = hit_wall_q;

endmodule

// File: tb/tb_sprite_mover.sv
`timescale 1ns/1ps
module tb_sprite_mover;

    localparam int HACTIVE = 800;
    localparam int VACTIVE = 600;
    localparam int R       = 50;
    localparam int VMAX    = 8;
    localparam int ACCEL   = 4;

    logic clk;
    logic reset;

    sprite_mover_if bus();

    sprite_mover #(
        .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .R(R),
        .VMAX(VMAX), .ACCEL_FRAMES(ACCEL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    x;
        int    y;
        bit    mov;
        bit    hit;
    } exp_t;

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        int         x;
        int         y;
        bit         mov;
        bit         hit;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[12];
    int         n_cmp;
    int         n_bad;
    logic [3:0] cur_btn;

    // Reference model state
    int m_x, m_y, m_spd, m_cnt;
    bit m_mov, m_hit;

    task automatic check_int(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_outputs(input string nm, input int ex, input int ey,
                                 input bit em, input bit eh);
        check_int({nm, ".x"},   int'(bus.centerX), ex);
        check_int({nm, ".y"},   int'(bus.centerY), ey);
        check_int({nm, ".mov"}, int'(bus.moving),  int'(em));
        check_int({nm, ".hit"}, int'(bus.hit_wall), int'(eh));
    endtask

    task automatic model_reset();
        m_x = HACTIVE / 2; m_y = VACTIVE / 2;
        m_spd = 0; m_cnt = 0; m_mov = 1'b0; m_hit = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_btn(input logic [3:0] b);
        @(negedge clk);
        cur_btn        = b;
        bus.btn_up     = b[3];
        bus.btn_down   = b[2];
        bus.btn_left   = b[1];
        bus.btn_right  = b[0];
        repeat (3) @(negedge clk);
    endtask

    // Push the expectation, pulse frame_tick, then pop and compare one cycle on.
    task automatic do_tick(input string nm, input int ex, input int ey,
                           input bit em, input bit eh);
        exp_t e;
        sbq.push_back('{name: nm, x: ex, y: ey, mov: em, hit: eh});
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty, got nothing, required one entry", nm);
        end else begin
            e = sbq.pop_front();
            check_outputs(e.name, e.x, e.y, e.mov, e.hit);
        end
    endtask

    task automatic model_tick(input string nm);
        int dx, dy, nx, ny;
        dx = int'(cur_btn[0]) - int'(cur_btn[1]);
        dy = int'(cur_btn[2]) - int'(cur_btn[3]);
        m_hit = 1'b0;
        if (dx == 0 && dy == 0) begin
            m_spd = 0; m_cnt = 0; m_mov = 1'b0;
        end else begin
            if (!m_mov) begin m_spd = 1; m_cnt = 0; end
            nx = m_x + dx * m_spd;
            ny = m_y + dy * m_spd;
            if (nx < R)                  begin nx = R;                 m_hit = 1'b1; end
            if (nx > HACTIVE - 1 - R)    begin nx = HACTIVE - 1 - R;   m_hit = 1'b1; end
            if (ny < R)                  begin ny = R;                 m_hit = 1'b1; end
            if (ny > VACTIVE - 1 - R)    begin ny = VACTIVE - 1 - R;   m_hit = 1'b1; end
            m_x = nx; m_y = ny;
            if (m_cnt == ACCEL - 1) begin
                m_cnt = 0;
                m_spd = (m_spd + 1 > VMAX) ? VMAX : m_spd + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_mov = 1'b1;
        end
        do_tick(nm, m_x, m_y, m_mov, m_hit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_cmp = 0; n_bad = 0;
        cur_btn = 4'b0000;
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        model_reset();

        // Right held: speed 1 for four frames, then 2, then 3; then a
        // direction change, a cancelling pair, and a restart.
        vecs[0]  = '{4'b0001, 401, 300, 1'b1, 1'b0};
        vecs[1]  = '{4'b0001, 402, 300, 1'b1, 1'b0};
        vecs[2]  = '{4'b0001, 403, 300, 1'b1, 1'b0};
        vecs[3]  = '{4'b0001, 404, 300, 1'b1, 1'b0};
        vecs[4]  = '{4'b0001, 406, 300, 1'b1, 1'b0};
        vecs[5]  = '{4'b0001, 408, 300, 1'b1, 1'b0};
        vecs[6]  = '{4'b0001, 410, 300, 1'b1, 1'b0};
        vecs[7]  = '{4'b0001, 412, 300, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 412, 303, 1'b1, 1'b0};
        vecs[9]  = '{4'b0011, 412, 303, 1'b0, 1'b0};
        vecs[10] = '{4'b0111, 412, 304, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 412, 304, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs("reset", 400, 300, 1'b0, 1'b0);

        set_btn(4'b0001);
        repeat (10) @(negedge clk);
        check_outputs("no_tick_hold", 400, 300, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            set_btn(vecs[i].btn);
            do_tick($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                    vecs[i].mov, vecs[i].hit);
        end

        // Ramp to VMAX and into the right wall.
        do_reset();
        set_btn(4'b0001);
        for (int i = 0; i < 28; i++) model_tick($sformatf("ramp%0d", i));
        check_int("ramp28_x", int'(bus.centerX), 512);
        model_tick("cruise_first");
        check_int("cruise_step_x", int'(bus.centerX), 520);
        guard = 0;
        while (m_x < HACTIVE - 1 - R && guard < 40) begin
            model_tick($sformatf("cruise%0d", guard));
            guard++;
        end
        check_int("wall_right_x", int'(bus.centerX), 749);
        check_int("wall_right_hit", int'(bus.hit_wall), 1);
        @(negedge clk);
        check_outputs("wall_hit_drop", 749, 300, 1'b1, 1'b0);
        model_tick("wall_again");
        check_int("wall_again_hit", int'(bus.hit_wall), 1);

        // Left wall, step back to 52, build speed 4 on Y, then swing left.
        do_reset();
        set_btn(4'b0010);
        guard = 0;
        while (m_x > R && guard < 60) begin
            model_tick($sformatf("left%0d", guard));
            guard++;
        end
        check_int("wall_left_x", int'(bus.centerX), 50);
        set_btn(4'b0000);
        model_tick("left_release");
        set_btn(4'b0001);
        model_tick("nudge1");
        model_tick("nudge2");
        check_int("nudge_x", int'(bus.centerX), 52);
        set_btn(4'b0000);
        model_tick("nudge_release");
        set_btn(4'b1000);
        for (int i = 0; i < 12; i++) model_tick($sformatf("up%0d", i));
        set_btn(4'b0010);
        model_tick("left_from_52");
        check_int("left52_x", int'(bus.centerX), 50);
        check_int("left52_hit", int'(bus.hit_wall), 1);

        // Reset mid-motion at speed 5, with a frame_tick in the same cycle.
        do_reset();
        set_btn(4'b0001);
        for (int i = 0; i < 16; i++) model_tick($sformatf("pre%0d", i));
        check_int("pre_reset_x", int'(bus.centerX), 440);
        reset = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        model_reset();
        check_outputs("mid_reset", 400, 300, 1'b0, 1'b0);
        set_btn(4'b0000);
        model_tick("post_reset_idle");
        set_btn(4'b0001);
        model_tick("restart");
        check_int("restart_x", int'(bus.centerX), 401);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
